// File: rtl/rim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rim_pkg
//  Description : Shared types and constants for the maze-path checker:
//                maze dimension, FSM state encoding, error codes, the
//                3-bit coordinate type and an adjacency helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rim_pkg;

  localparam int N       = 8;   // maze is N x N
  localparam int COORD_W = 3;   // row/col coordinate width

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_PATH = 3'd2,
    ST_CHECK     = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_REPORT    = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_START   = 3'd1;
  localparam logic [2:0] ERR_WALL    = 3'd2;
  localparam logic [2:0] ERR_ADJ     = 3'd3;
  localparam logic [2:0] ERR_EARLY   = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_LONG    = 3'd6;
  localparam logic [2:0] ERR_INVAL   = 3'd7;

  // True when (r1,c1) differs from (r0,c0) by exactly one step in exactly
  // one coordinate. A repeated cell (distance 0) is not adjacent.
  function automatic logic is_adjacent(input coord_t r0, input coord_t c0,
                                       input coord_t r1, input coord_t c1);
    coord_t dr;
    coord_t dc;
    dr = (r1 > r0) ? (r1 - r0) : (r0 - r1);
    dc = (c1 > c0) ? (c1 - c0) : (c0 - c1);
    return ((dr == coord_t'(1)) && (dc == coord_t'(0))) ||
           ((dr == coord_t'(0)) && (dc == coord_t'(1)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/rim_maze_store.sv
`default_nettype none
// ============================================================================
//  Module      : rim_maze_store
//  Description : N x N single-bit maze store. One full row is written per
//                cycle; any single cell is read combinationally.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk     in   clock
//    rst     in   asynchronous active-high reset, clears every cell
//    we      in   row write enable
//    waddr   in   row index to write
//    wdata   in   row contents, bit c = column c (1 = open)
//    rd_row  in   read row
//    rd_col  in   read column
//    rd_bit  out  cell value at (rd_row, rd_col)
// ============================================================================
module rim_maze_store #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] rd_row,
  input  logic [AW-1:0] rd_col,
  output logic          rd_bit
);

  logic [N-1:0] rows_w [N];

  for (genvar r = 0; r < N; r++) begin : g_row
    logic [N-1:0] row_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        row_q <= '0;
      end else if (we && (waddr == AW'(r))) begin
        row_q <= wdata;
      end
    end

    assign rows_w[r] = row_q;
  end

  assign rd_bit = rows_w[rd_row][rd_col];

endmodule
`default_nettype wire

// File: rtl/rim_path_checker.sv
`default_nettype none
// ============================================================================
//  Module      : rim_path_checker
//  Description : Consumer end of the maze-router output. Loads the 8x8 maze,
//                then follows the router's path stream and checks that it
//                starts at (0,0), stays on open cells, moves one orthogonal
//                step at a time, ends at (N-1,N-1) and is not too long.
//                Reports a one-cycle done pulse with pass/err_code/step_cnt.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk         in   clock, all state on rising edge
//    rst         in   asynchronous active-high reset
//    in_valid    in   maze row valid, row 0 first
//    maze        in   maze row, bit c = column c, 1 = open
//    path_valid  in   path cell valid
//    path_row    in   path cell row
//    path_col    in   path cell column
//    done        out  one-cycle verdict pulse
//    pass        out  last path legal, held until the next load starts
//    err_code    out  error code of the last path (0 = none)
//    step_cnt    out  cells accepted in the current/last path
// ============================================================================
module rim_path_checker
  import rim_pkg::*;
#(
  parameter int MAX_STEPS = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] maze,
  input  logic         path_valid,
  input  logic [2:0]   path_row,
  input  logic [2:0]   path_col,
  output logic         done,
  output logic         pass,
  output logic [2:0]   err_code,
  output logic [6:0]   step_cnt
);

  localparam int          TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam coord_t      LAST     = coord_t'(N - 1);
  localparam logic [6:0]  STEP_MAX = 7'(MAX_STEPS);
  localparam logic [6:0]  STEP_SAT = 7'd127;

  state_t           state_q;
  coord_t           row_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  coord_t           prev_row_q;
  coord_t           prev_col_q;
  logic             done_q;
  logic             pass_q;
  logic [2:0]       err_q;
  logic [6:0]       step_q;

  logic             store_we;
  coord_t           store_waddr;
  logic             cell_open;
  logic             first_cell;
  logic [6:0]       step_d;
  logic [2:0]       cell_err;

  // Rows are written from IDLE (always row 0) and LOAD (row counter).
  assign store_we    = in_valid && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign store_waddr = (state_q == ST_IDLE) ? coord_t'(0) : row_cnt_q;

  rim_maze_store #(
    .N (N)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .we     (store_we),
    .waddr  (store_waddr),
    .wdata  (maze),
    .rd_row (path_row),
    .rd_col (path_col),
    .rd_bit (cell_open)
  );

  // The cell seen in WAIT_PATH is always step 1.
  assign first_cell = (state_q == ST_WAIT_PATH);
  assign step_d     = (step_q == STEP_SAT) ? STEP_SAT : (step_q + 7'd1);

  // Per-cell checks in priority order; only the first failure is reported.
  always_comb begin
    cell_err = ERR_NONE;
    if (first_cell && ((path_row != coord_t'(0)) || (path_col != coord_t'(0)))) begin
      cell_err = ERR_START;
    end else if (!cell_open) begin
      cell_err = ERR_WALL;
    end else if (!first_cell &&
                 !is_adjacent(prev_row_q, prev_col_q, path_row, path_col)) begin
      cell_err = ERR_ADJ;
    end else if (step_d > STEP_MAX) begin
      cell_err = ERR_LONG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      prev_row_q <= '0;
      prev_col_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= ERR_NONE;
      step_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            row_cnt_q <= coord_t'(1);
            pass_q    <= 1'b0;
            err_q     <= ERR_NONE;
            step_q    <= '0;
            state_q   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          // path_valid is deliberately ignored here, including in the
          // cycle that carries the last row.
          if (in_valid) begin
            row_cnt_q <= row_cnt_q + coord_t'(1);
            if (row_cnt_q == LAST) begin
              tmo_cnt_q <= '0;
              state_q   <= ST_WAIT_PATH;
            end
          end
        end

        ST_WAIT_PATH, ST_CHECK: begin
          if (in_valid) begin
            err_q   <= ERR_INVAL;
            state_q <= ST_DRAIN;
          end else if (path_valid) begin
            step_q     <= step_d;
            prev_row_q <= path_row;
            prev_col_q <= path_col;
            if (cell_err != ERR_NONE) begin
              // Path is still streaming: swallow the rest before reporting.
              err_q   <= cell_err;
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_CHECK;
            end
          end else if (state_q == ST_CHECK) begin
            // First idle cycle after a path: judge where it ended.
            if ((prev_row_q == LAST) && (prev_col_q == LAST)) begin
              pass_q <= 1'b1;
              err_q  <= ERR_NONE;
            end else begin
              err_q  <= ERR_EARLY;
            end
            done_q  <= 1'b1;
            state_q <= ST_REPORT;
          end else if (tmo_cnt_q == TMO_LAST) begin
            err_q   <= ERR_TIMEOUT;
            done_q  <= 1'b1;
            state_q <= ST_REPORT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end

        ST_DRAIN: begin
          if (!path_valid && !in_valid) begin
            done_q  <= 1'b1;
            state_q <= ST_REPORT;
          end
        end

        ST_REPORT: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign err_code = err_q;
  assign step_cnt = step_q;

endmodule
`default_nettype wire

// File: tb/tb_rim_path_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rim_path_checker
//  Description : Directed self-checking bench for rim_path_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rim_path_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] maze = 8'h00;
  logic       path_valid = 1'b0;
  logic [2:0] path_row = 3'd0;
  logic [2:0] path_col = 3'd0;
  logic       done;
  logic       pass;
  logic [2:0] err_code;
  logic [6:0] step_cnt;

  int total = 0;
  int bad   = 0;

  logic [5:0] path_q [$];   // {row, col} per cell

  localparam logic [63:0] OPEN_MAZE = {64{1'b1}};
  localparam logic [63:0] WALL_MAZE = 64'hFFFF_FFFF_00FF_FFFF; // row 3 closed

  always #5 clk = ~clk;

  rim_path_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .maze       (maze),
    .path_valid (path_valid),
    .path_row   (path_row),
    .path_col   (path_col),
    .done       (done),
    .pass       (pass),
    .err_code   (err_code),
    .step_cnt   (step_cnt)
  );

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic load_maze(input logic [63:0] m, input int gap_after);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      in_valid = 1'b1;
      maze     = m[r*8 +: 8];
      if (r == gap_after) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_path();
    foreach (path_q[i]) begin
      @(negedge clk);
      path_valid = 1'b1;
      {path_row, path_col} = path_q[i];
    end
    @(negedge clk);
    path_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (pass !== 1'b0)      begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
    total++; if (err_code !== 3'd0)  begin bad++; $display("FAIL reset_err got=%0d want=0", err_code); end
    total++; if (step_cnt !== 7'd0)  begin bad++; $display("FAIL reset_step got=%0d want=0", step_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_path();
    int n;
    load_maze(OPEN_MAZE, -1);
    path_q.delete();
    for (int c = 0; c < 8; c++) path_q.push_back({3'd0, 3'(c)});
    for (int r = 1; r < 8; r++) path_q.push_back({3'(r), 3'd7});
    send_path();
    wait_done(20, n);
    total++; if (n !== 1)            begin bad++; $display("FAIL clean_latency got=%0d want=1", n); end
    total++; if (pass !== 1'b1)      begin bad++; $display("FAIL clean_pass got=%b want=1", pass); end
    total++; if (err_code !== 3'd0)  begin bad++; $display("FAIL clean_err got=%0d want=0", err_code); end
    total++; if (step_cnt !== 7'd15) begin bad++; $display("FAIL clean_step got=%0d want=15", step_cnt); end
    @(negedge clk);
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL clean_done_width got=%b want=0", done); end
    total++; if (pass !== 1'b1)      begin bad++; $display("FAIL clean_pass_hold got=%b want=1", pass); end
  endtask

  task automatic test_bad_start();
    int n;
    load_maze(OPEN_MAZE, -1);
    path_q.delete();
    path_q.push_back({3'd0, 3'd1});
    path_q.push_back({3'd0, 3'd2});
    path_q.push_back({3'd0, 3'd3});
    send_path();
    wait_done(20, n);
    total++; if (n !== 1)            begin bad++; $display("FAIL start_latency got=%0d want=1", n); end
    total++; if (err_code !== 3'd1)  begin bad++; $display("FAIL start_err got=%0d want=1", err_code); end
    total++; if (pass !== 1'b0)      begin bad++; $display("FAIL start_pass got=%b want=0", pass); end
    total++; if (step_cnt !== 7'd1)  begin bad++; $display("FAIL start_step got=%0d want=1", step_cnt); end
    @(negedge clk);
  endtask

  task automatic test_wall();
    int n;
    load_maze(WALL_MAZE, 2);   // includes a gap in the row stream
    path_q.delete();
    for (int r = 0; r < 6; r++) path_q.push_back({3'(r), 3'd0});
    send_path();
    wait_done(20, n);
    total++; if (n !== 1)            begin bad++; $display("FAIL wall_latency got=%0d want=1", n); end
    total++; if (err_code !== 3'd2)  begin bad++; $display("FAIL wall_err got=%0d want=2", err_code); end
    total++; if (step_cnt !== 7'd4)  begin bad++; $display("FAIL wall_step got=%0d want=4", step_cnt); end
    @(negedge clk);
    total++; if (step_cnt !== 7'd4)  begin bad++; $display("FAIL wall_step_hold got=%0d want=4", step_cnt); end
  endtask

  task automatic test_non_adjacent();
    int n;
    load_maze(OPEN_MAZE, -1);
    path_q.delete();
    path_q.push_back({3'd0, 3'd0});
    path_q.push_back({3'd1, 3'd1});
    send_path();
    wait_done(20, n);
    total++; if (n !== 1)            begin bad++; $display("FAIL adj_latency got=%0d want=1", n); end
    total++; if (err_code !== 3'd3)  begin bad++; $display("FAIL adj_err got=%0d want=3", err_code); end
    total++; if (step_cnt !== 7'd2)  begin bad++; $display("FAIL adj_step got=%0d want=2", step_cnt); end
    @(negedge clk);
    // Repeated cell is also a non-adjacent step.
    load_maze(OPEN_MAZE, -1);
    path_q.delete();
    path_q.push_back({3'd0, 3'd0});
    path_q.push_back({3'd0, 3'd1});
    path_q.push_back({3'd0, 3'd1});
    send_path();
    wait_done(20, n);
    total++; if (err_code !== 3'd3)  begin bad++; $display("FAIL repeat_err got=%0d want=3", err_code); end
    total++; if (step_cnt !== 7'd3)  begin bad++; $display("FAIL repeat_step got=%0d want=3", step_cnt); end
    @(negedge clk);
  endtask

  task automatic test_early_end();
    int n;
    load_maze(OPEN_MAZE, -1);
    path_q.delete();
    path_q.push_back({3'd0, 3'd0});
    path_q.push_back({3'd0, 3'd1});
    send_path();
    wait_done(20, n);
    total++; if (n !== 1)            begin bad++; $display("FAIL early_latency got=%0d want=1", n); end
    total++; if (err_code !== 3'd4)  begin bad++; $display("FAIL early_err got=%0d want=4", err_code); end
    total++; if (step_cnt !== 7'd2)  begin bad++; $display("FAIL early_step got=%0d want=2", step_cnt); end
    total++; if (pass !== 1'b0)      begin bad++; $display("FAIL early_pass got=%b want=0", pass); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    load_maze(OPEN_MAZE, -1);
    wait_done(400, n);
    total++; if (n !== 255)          begin bad++; $display("FAIL tmo_latency got=%0d want=255", n); end
    total++; if (err_code !== 3'd5)  begin bad++; $display("FAIL tmo_err got=%0d want=5", err_code); end
    total++; if (step_cnt !== 7'd0)  begin bad++; $display("FAIL tmo_step got=%0d want=0", step_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_check();
    int n;
    load_maze(OPEN_MAZE, -1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      path_valid = 1'b1;
      path_row   = 3'd0;
      path_col   = 3'(c);
    end
    @(negedge clk);
    total++; if (step_cnt !== 7'd3)  begin bad++; $display("FAIL midrst_pre_step got=%0d want=3", step_cnt); end
    rst = 1'b1;
    #1;
    total++; if (step_cnt !== 7'd0)  begin bad++; $display("FAIL midrst_step got=%0d want=0", step_cnt); end
    total++; if (err_code !== 3'd0)  begin bad++; $display("FAIL midrst_err got=%0d want=0", err_code); end
    total++; if ({done, pass} !== 2'b00) begin bad++; $display("FAIL midrst_flags got=%b want=00", {done, pass}); end
    @(negedge clk);
    rst        = 1'b0;
    path_valid = 1'b0;
    load_maze(OPEN_MAZE, -1);
    path_q.delete();
    for (int c = 0; c < 8; c++) path_q.push_back({3'd0, 3'(c)});
    for (int r = 1; r < 8; r++) path_q.push_back({3'(r), 3'd7});
    send_path();
    wait_done(20, n);
    total++; if (pass !== 1'b1)      begin bad++; $display("FAIL midrst_repass got=%b want=1", pass); end
    total++; if (step_cnt !== 7'd15) begin bad++; $display("FAIL midrst_restep got=%0d want=15", step_cnt); end
    @(negedge clk);
  endtask

  task automatic test_too_long();
    int n;
    load_maze(OPEN_MAZE, -1);
    path_q.delete();
    // Boustrophedon covering all 64 cells, ending at (7,0), then (6,0).
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        path_q.push_back({3'(r), ((r % 2) == 0) ? 3'(k) : 3'(7 - k)});
    path_q.push_back({3'd6, 3'd0});
    send_path();
    wait_done(20, n);
    total++; if (n !== 1)            begin bad++; $display("FAIL long_latency got=%0d want=1", n); end
    total++; if (err_code !== 3'd6)  begin bad++; $display("FAIL long_err got=%0d want=6", err_code); end
    total++; if (step_cnt !== 7'd65) begin bad++; $display("FAIL long_step got=%0d want=65", step_cnt); end
    @(negedge clk);
  endtask

  task automatic test_inval_during_check();
    int n;
    logic [7:0] vec [6];  // {in_valid, path_valid, row, col}
    vec[0] = {1'b0, 1'b1, 3'd0, 3'd0};
    vec[1] = {1'b0, 1'b1, 3'd0, 3'd1};
    vec[2] = {1'b1, 1'b1, 3'd0, 3'd2};
    vec[3] = {1'b0, 1'b1, 3'd0, 3'd3};
    vec[4] = {1'b1, 1'b0, 3'd0, 3'd0};
    vec[5] = {1'b0, 1'b0, 3'd0, 3'd0};
    load_maze(OPEN_MAZE, -1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL inval_early_done cycle=%0d got=%b want=0", i, done); end
      end
      {in_valid, path_valid, path_row, path_col} = vec[i];
    end
    wait_done(20, n);
    total++; if (n !== 1)            begin bad++; $display("FAIL inval_latency got=%0d want=1", n); end
    total++; if (err_code !== 3'd7)  begin bad++; $display("FAIL inval_err got=%0d want=7", err_code); end
    total++; if (pass !== 1'b0)      begin bad++; $display("FAIL inval_pass got=%b want=0", pass); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clean_path();
    test_bad_start();
    test_wall();
    test_non_adjacent();
    test_early_end();
    test_timeout();
    test_reset_mid_check();
    test_too_long();
    test_inval_during_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rim_path_checker.md
Name: rim_path_checker

Overview:
- Consumer end of the maze-router output interface.
- Loads the same 8x8 maze the router receives (8 rows on in_valid/maze).
- Watches the router's out_valid/out_row/out_col stream and checks that the path is legal.
- Reports pass/fail, an error code and the step count. Used as an in-system monitor and as the bench scoreboard.

Parameters:
N, 8, maze dimension (rows = cols = N; coordinates 3 bits)
MAX_STEPS, 64, longest accepted path in cells; exceeding it is an error
TIMEOUT, 255, cycles allowed between end of load and first path_valid

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  maze row valid; row 0 first
maze  input  8  one maze row; bit c = column c; 1 = open, 0 = wall
path_valid  input  1  path cell valid (router out_valid)
path_row  input  3  path cell row
path_col  input  3  path cell column
done  output  1  one-cycle pulse: verdict available
pass  output  1  1 = last path legal; held until next load starts
err_code  output  3  0 none, 1 bad start, 2 wall cell, 3 non-adjacent step, 4 early end, 5 timeout, 6 too long, 7 in_valid during path
step_cnt  output  7  cells accepted in the current or last path; held with pass

Behaviour:
- Reset (any time, including mid-operation): state IDLE; done=0, pass=0, err_code=0, step_cnt=0; maze store cleared to 0; load row counter 0.
- Clock and reset are exactly as decided: one clock, clk; reset rst, asynchronous, active-high.
- States: IDLE, LOAD, WAIT_PATH, CHECK, DRAIN, REPORT.
- IDLE: in_valid=1 stores maze into row 0, row counter becomes 1, pass/err_code/step_cnt clear, go to LOAD.
- LOAD: each in_valid=1 cycle stores maze into the row at the counter and increments it. Gaps (in_valid=0) are tolerated. Storing row N-1 goes to WAIT_PATH and clears the timeout counter.
- WAIT_PATH:
  - path_valid=1 goes to CHECK with that cell evaluated as step 1.
  - Otherwise the counter increments. Reaching TIMEOUT sets err 5 and goes to REPORT.
  - path_valid=1 in the same cycle as the last maze row is not possible; a cell arriving in that cycle is ignored.
- Per accepted cell in CHECK, checks run in priority order:
  - (a) step 1 must be (0,0), else err 1.
  - (b) the maze cell must be 1, else err 2.
  - (c) steps after the first must differ from the previous cell by exactly 1 in exactly one coordinate, else err 3. A repeated cell is err 3.
  - (d) step_cnt must stay <= MAX_STEPS, else err 6.
  - step_cnt increments (saturating at 127) on every accepted cell, including the failing one.
  - On the first error: latch err_code. If path_valid is still 1 go to DRAIN, else go to REPORT.
- Path end: first path_valid=0 cycle in CHECK. If the previous cell was (N-1,N-1) then pass=1, err 0; else err 4. Go to REPORT.
- in_valid=1 while in WAIT_PATH or CHECK: err 7, go to DRAIN. That row is not stored.
- DRAIN: ignore all inputs until path_valid=0 and in_valid=0 in the same cycle, then go to REPORT.
- REPORT: done=1 for exactly one cycle, then go to IDLE. pass, err_code and step_cnt remain stable.
- Latency: done is asserted 1 cycle after the path_valid falling edge for a clean path, or after the drain/timeout condition.
- in_valid=1 in the REPORT cycle is ignored. A new load starts only from IDLE.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package rim_pkg: N, state enum (6 states, 3 bits), err_code constants (ERR_NONE..ERR_INVAL), coordinate typedef (3-bit row/col).
- Sub-module rim_maze_store: N x N bit store with row write port (we, waddr, wdata) and single-bit combinational read port (row, col). Async clear on rst.
- The FSM and checks stay in rim_path_checker.

Test Plan:
- Open maze (all rows 8'hFF), path (0,0)->(0,1)...(0,7)->(1,7)...(7,7), 15 cells contiguous -> done 1 cycle after path_valid falls, pass=1, err_code=0, step_cnt=15.
- Same maze, path starts at (0,1) -> err_code=1, pass=0, step_cnt=1; done after path_valid falls (DRAIN exited).
- Row 3 = 8'h00, path going down column 0 through (3,0) -> err_code=2 at step 4, step_cnt=4 held after done.
- Open maze, path (0,0)->(1,1) -> err_code=3, step_cnt=2; path (0,0)->(0,1) then path_valid low -> err_code=4, step_cnt=2.
- Load 8 rows, hold path_valid=0 for 255 cycles -> err_code=5, done pulse. Separately, rst=1 pulsed mid-CHECK -> all outputs 0 immediately; a subsequent full load and legal path passes.
- Open maze, 65-cell legal snake path -> err_code=6 at step 65. in_valid=1 asserted during CHECK -> err_code=7, done only after both in_valid and path_valid are low.
